// File: rtl/decode_q.sv
// decode_q: instruction queue between fetch and decode, feeding a registered control bundle to execute.
// Optional feature: define DECODE_Q_BYPASS_EN to decode straight from fetch when the queue is empty.
module decode_q #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_valid,
    input  logic [31:0]   fetch_instr,
    output logic          fetch_ready,
    input  logic          flush,
    input  logic          stall,
    output logic          id_valid,
    output logic          id_jump,
    output logic          id_link,
    output logic          id_regwrite,
    output logic          id_regdst,
    output logic          id_alusrc,
    output logic          id_memwrite,
    output logic          id_memtoreg,
    output logic [2:0]    id_bpctl,
    output logic [3:0]    id_aluctl,
    output logic [15:0]   id_imm,
    output logic [25:0]   id_jtgt,
    output logic          id_illegal,
    output logic [CW-1:0] q_count
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic        jump;
        logic        link;
        logic        regwrite;
        logic        regdst;
        logic        alusrc;
        logic        memwrite;
        logic        memtoreg;
        logic [2:0]  bpctl;
        logic [3:0]  aluctl;
        logic [15:0] imm;
        logic [25:0] jtgt;
        logic        illegal;
    } bundle_t;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    bundle_t       r_bundle;

    logic          w_empty;
    logic          w_advance;
    logic          w_push;
    logic          w_pop;
    logic          w_bypass;
    logic          w_write;
    logic          w_load;
    logic [31:0]   w_instr;
    logic [5:0]    w_op;
    logic [5:0]    w_funct;
    logic [4:0]    w_rt;
    logic [7:0]    w_ctrl;
    logic          w_op_bad;
    logic          w_fn_bad;
    logic [3:0]    w_aluctl;
    logic [2:0]    w_bpctl;
    bundle_t       w_dec;

    assign fetch_ready = !reset && (r_count < CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_advance   = !stall || !r_valid;
    assign w_push      = fetch_valid && fetch_ready && !flush;
    assign w_pop       = w_advance && !w_empty && !flush;
`ifdef DECODE_Q_BYPASS_EN
    assign w_bypass    = w_advance && w_empty && w_push;
`else
    assign w_bypass    = 1'b0;
`endif
    assign w_write     = w_push && !w_bypass;
    assign w_load      = !w_empty || w_bypass;

    // With an empty queue the only word that can be decoded is the one on the fetch port.
    assign w_instr = w_empty ? fetch_instr : r_mem[r_rd_ptr];
    assign w_op    = w_instr[31:26];
    assign w_funct = w_instr[5:0];
    assign w_rt    = w_instr[20:16];

    // w_ctrl = {regwrite, regdst, alusrc, memwrite, memtoreg, aluop[2:0]}
    always_comb begin
        w_ctrl   = 8'b0000_0000;
        w_op_bad = 1'b0;
        case (w_op)
            6'b000000:                     w_ctrl = 8'b1100_0100;
            6'b100011:                     w_ctrl = 8'b1010_1000;
            6'b101011:                     w_ctrl = 8'b0011_0000;
            6'b000100, 6'b000101:          w_ctrl = 8'b0000_0010;
            6'b001000, 6'b001001:          w_ctrl = 8'b1010_0000;
            6'b001100:                     w_ctrl = 8'b1010_0001;
            6'b001101:                     w_ctrl = 8'b1010_0011;
            6'b001110:                     w_ctrl = 8'b1010_0101;
            6'b001010:                     w_ctrl = 8'b1010_0110;
            6'b001111:                     w_ctrl = 8'b1010_0111;
            6'b000010, 6'b000011, 6'b000001,
            6'b000110, 6'b000111:          w_ctrl = 8'b0000_0000;
            default:                       w_op_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_aluctl = 4'b0000;
        w_fn_bad = 1'b0;
        case (w_ctrl[2:0])
            3'b000: w_aluctl = 4'b0010;
            3'b010: w_aluctl = 4'b0110;
            3'b001: w_aluctl = 4'b0000;
            3'b011: w_aluctl = 4'b0001;
            3'b101: w_aluctl = 4'b0101;
            3'b111: w_aluctl = 4'b1001;
            3'b110: w_aluctl = 4'b0111;
            default: begin
                case (w_funct)
                    6'b011000:            w_aluctl = 4'b1111;
                    6'b011010:            w_aluctl = 4'b1110;
                    6'b100100:            w_aluctl = 4'b0000;
                    6'b100101:            w_aluctl = 4'b0001;
                    6'b100000, 6'b100001: w_aluctl = 4'b0010;
                    6'b100110:            w_aluctl = 4'b0101;
                    6'b100010, 6'b100011: w_aluctl = 4'b0110;
                    6'b101010, 6'b101011: w_aluctl = 4'b0111;
                    6'b010000:            w_aluctl = 4'b1010;
                    6'b010010:            w_aluctl = 4'b1011;
                    6'b000110:            w_aluctl = 4'b0100;
                    6'b000010:            w_aluctl = 4'b1101;
                    6'b000000:            w_aluctl = 4'b1100;
                    6'b000100:            w_aluctl = 4'b0011;
                    6'b000011:            w_aluctl = 4'b1000;
                    default:              w_fn_bad = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        w_bpctl = 3'b000;
        case (w_op)
            6'b000100: w_bpctl = 3'b001;
            6'b000110: w_bpctl = 3'b100;
            6'b000111: w_bpctl = 3'b101;
            6'b000001: begin
                case (w_rt)
                    5'b00001: w_bpctl = 3'b010;
                    5'b10001: w_bpctl = 3'b011;
                    5'b00000: w_bpctl = 3'b110;
                    5'b10000: w_bpctl = 3'b111;
                    default:  w_bpctl = 3'b000;
                endcase
            end
            default:   w_bpctl = 3'b000;
        endcase
    end

    always_comb begin
        w_dec          = '0;
        w_dec.regwrite = w_ctrl[7] && !w_fn_bad;
        w_dec.regdst   = w_ctrl[6];
        w_dec.alusrc   = w_ctrl[5];
        w_dec.memwrite = w_ctrl[4];
        w_dec.memtoreg = w_ctrl[3];
        w_dec.aluctl   = w_aluctl;
        w_dec.bpctl    = w_bpctl;
        w_dec.jump     = (w_op == 6'b000010) || (w_op == 6'b000011);
        w_dec.link     = (w_op == 6'b000011) || (w_bpctl == 3'b011) || (w_bpctl == 3'b111);
        w_dec.imm      = w_instr[15:0];
        w_dec.jtgt     = w_instr[25:0];
        w_dec.illegal  = w_op_bad || w_fn_bad;
    end

    // Queue storage carries no reset; occupancy alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_ptr] <= fetch_instr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_bundle <= '0;
        end else begin
            if (w_write)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_write) - CW'(w_pop);
            if (w_advance) begin
                r_valid  <= w_load;
                r_bundle <= w_load ? w_dec : '0;
            end
        end
    end

    assign id_valid    = r_valid;
    assign id_jump     = r_bundle.jump;
    assign id_link     = r_bundle.link;
    assign id_regwrite = r_bundle.regwrite;
    assign id_regdst   = r_bundle.regdst;
    assign id_alusrc   = r_bundle.alusrc;
    assign id_memwrite = r_bundle.memwrite;
    assign id_memtoreg = r_bundle.memtoreg;
    assign id_bpctl    = r_bundle.bpctl;
    assign id_aluctl   = r_bundle.aluctl;
    assign id_imm      = r_bundle.imm;
    assign id_jtgt     = r_bundle.jtgt;
    assign id_illegal  = r_bundle.illegal;
    assign q_count     = r_count;
endmodule
